// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_defs (package)
//  Brief    : Shared opcodes, NOP encoding and LM/SM sequencer state encoding
//  Revision : 1.0  initial release
// ============================================================================
package cpu_defs;

    localparam logic [3:0]  c_OP_LM = 4'b0110;
    localparam logic [3:0]  c_OP_SM = 4'b0111;
    localparam logic [15:0] c_NOP   = 16'hF000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } seqState_t;

endpackage
`default_nettype wire

// File: rtl/lsb_find_8.sv
`default_nettype none
// ============================================================================
//  Module   : lsb_find_8
//  Brief    : Combinational lowest-set-bit priority encoder, 8-bit input
//  Revision : 1.0  initial release
// ============================================================================
module lsb_find_8 (
    input  logic [7:0] mask,
    output logic [2:0] index,
    output logic       any
);

    // Scan downward so the lowest set bit is the last (winning) assignment.
    always_comb begin
        index = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                index = i[2:0];
            end
        end
    end

    assign any = |mask;

endmodule
`default_nettype wire

// File: rtl/lm_sm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : lm_sm_sequencer
//  Brief    : Expands LM/SM into one micro-op per mask bit, stalling fetch
//  Revision : 1.0  initial release
// ============================================================================
module lm_sm_sequencer
    import cpu_defs::*;
#(
    parameter logic [3:0] OP_LM  = c_OP_LM,
    parameter logic [3:0] OP_SM  = c_OP_SM,
    parameter int         MASK_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic        valid,
    input  logic        stall_in,
    input  logic        flush,
    output logic        modify_ir,
    output logic [2:0]  modify_pr2_ra,
    output logic        first_multiple,
    output logic        stall_fetch,
    output logic        kill
);

    seqState_t         r_state;
    seqState_t         w_stateNext;
    logic [MASK_W-1:0] r_remaining;
    logic [MASK_W-1:0] w_remainingNext;

    logic [MASK_W-1:0] w_irMask;
    logic [MASK_W-1:0] w_irRest;
    logic [MASK_W-1:0] w_remRest;
    logic [2:0]        w_irIdx;
    logic [2:0]        w_remIdx;
    logic              w_irAny;
    logic              w_remAny;
    logic              w_isMultiple;
    logic              w_unusedIr;

    assign w_irMask     = ir[MASK_W-1:0];
    assign w_isMultiple = valid & ((ir[15:12] == OP_LM) | (ir[15:12] == OP_SM));
    assign w_unusedIr   = ^ir[11:MASK_W];

    // x & (x-1) drops the lowest set bit; nonzero result means more work remains.
    assign w_irRest  = w_irMask & (w_irMask - MASK_W'(1));
    assign w_remRest = r_remaining & (r_remaining - MASK_W'(1));

    lsb_find_8 u_lsbIr (
        .mask  (w_irMask),
        .index (w_irIdx),
        .any   (w_irAny)
    );

    lsb_find_8 u_lsbRem (
        .mask  (r_remaining),
        .index (w_remIdx),
        .any   (w_remAny)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_remaining <= w_remainingNext;
        end
    end

    always_comb begin
        w_stateNext     = r_state;
        w_remainingNext = r_remaining;
        modify_ir       = 1'b0;
        modify_pr2_ra   = 3'd0;
        first_multiple  = 1'b0;
        stall_fetch     = 1'b0;
        kill            = 1'b0;

        if (flush) begin
            // Kill any sequence and release fetch so it can redirect.
            w_stateNext     = IDLE;
            w_remainingNext = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_isMultiple) begin
                        if (w_irAny) begin
                            modify_ir      = 1'b1;
                            modify_pr2_ra  = w_irIdx;
                            first_multiple = 1'b1;
                            stall_fetch    = |w_irRest;
                            if (!stall_in) begin
                                w_remainingNext = w_irRest;
                                w_stateNext     = (|w_irRest) ? SEQ : IDLE;
                            end
                        end else begin
                            kill = 1'b1;
                        end
                    end
                end
                SEQ: begin
                    modify_ir     = w_remAny;
                    modify_pr2_ra = w_remIdx;
                    stall_fetch   = |w_remRest;
                    if (!stall_in) begin
                        w_remainingNext = w_remRest;
                        w_stateNext     = (|w_remRest) ? SEQ : IDLE;
                    end
                end
                default: begin
                    w_stateNext     = IDLE;
                    w_remainingNext = '0;
                end
            endcase
        end

        // Outputs fall to zero the moment reset asserts, not at the next edge.
        if (!reset) begin
            modify_ir      = 1'b0;
            modify_pr2_ra  = 3'd0;
            first_multiple = 1'b0;
            stall_fetch    = 1'b0;
            kill           = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
- Sits in the decode stage, between the IF/ID register and pipeline register 2 (ID/RR).
- Drives PR2's multiple-instruction controls: modify_ir, modify_pr2_ra and first_multiple. It also drives the fetch stall.
- Expands a load-multiple (LM) or store-multiple (SM) instruction into one micro-op per set bit of the register mask. For each micro-op, the sequencer rewrites IR[11:9] with the target register index.
- Holds PC and IF/ID until the last micro-op has issued.

Parameters:
- OP_LM, 4'b0110, opcode IR[15:12] for load-multiple
- OP_SM, 4'b0111, opcode IR[15:12] for store-multiple
- MASK_W, 8, width of the register-list field IR[MASK_W-1:0]; bit i selects register Ri

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ir  in  16  instruction currently held in IF/ID
- valid  in  1  IF/ID holds a real (non-bubble) instruction
- stall_in  in  1  downstream stall (load-use hazard); freezes the sequencer
- flush  in  1  branch/jump kill; same signal that drives PR2's flush
- modify_ir  out  1  to PR2: replace IR[11:9] with modify_pr2_ra
- modify_pr2_ra  out  3  to PR2: register index for the current micro-op
- first_multiple  out  1  to PR2: first micro-op of the sequence (memory address uses the base unmodified)
- stall_fetch  out  1  hold PC and IF/ID this cycle
- kill  out  1  inject a NOP into PR2 for an LM/SM with an empty mask

Behaviour:
- Reset: one clock, reset asynchronous and active-low.
  - While reset is low: state=IDLE, remaining=0, and all outputs are forced to 0.
- States:
  - IDLE: no sequence in flight.
  - SEQ: remaining mask is nonzero; micro-ops are still pending.
- is_multiple = valid & (ir[15:12]==OP_LM | ir[15:12]==OP_SM).
- Outputs are Mealy (combinational on state, remaining and ir). Index selection uses lsb(x) = index of the lowest set bit.
- IDLE, is_multiple, mask = ir[7:0] nonzero:
  - modify_ir=1, modify_pr2_ra=lsb(mask), first_multiple=1.
  - stall_fetch = 1 if the mask has more than one set bit.
  - On the clock edge (stall_in=0, flush=0): remaining <= mask with the lsb bit cleared. If remaining is nonzero, go to SEQ; otherwise stay in IDLE.
- IDLE, is_multiple, mask == 0:
  - kill=1 for exactly that cycle; all other outputs 0; stay in IDLE.
- IDLE, not is_multiple: all outputs 0.
- SEQ:
  - modify_ir=1, modify_pr2_ra=lsb(remaining), first_multiple=0.
  - stall_fetch = 1 unless remaining has exactly one set bit (last micro-op).
  - On the clock edge (stall_in=0): clear the lsb bit of remaining. Go to IDLE when the result is 0.
  - ir is ignored in SEQ, because IF/ID is held stable by stall_fetch.
- stall_in=1: state and remaining hold. Outputs keep their current values so that PR2 re-captures the same micro-op.
- flush=1 (priority over everything except reset):
  - Next state is IDLE, remaining is 0, and no new sequence starts that cycle.
  - modify_ir, first_multiple and kill are 0. stall_fetch is 0 so that fetch can redirect.
- Simultaneous flush and stall_in: flush wins.
- Latency: an N-bit mask issues N micro-ops in N non-stalled cycles. stall_fetch is high for N-1 of those cycles.
- modify_pr2_ra is always 3 bits; MASK_W=8 maps directly onto R0..R7.

Decomposition:
- Shared package (cpu_defs):
  - OP_LM and OP_SM opcode constants
  - NOP encoding 16'hF000
  - state encoding IDLE=1'b0, SEQ=1'b1
- Sub-module lsb_find_8: combinational lowest-set-bit priority encoder (8-bit in, 3-bit index, 1-bit any). Instantiated twice: once on ir[7:0], once on remaining.

Test Plan:
- LM ir=16'h60A5 (mask 8'hA5), valid=1, no stalls:
  - modify_pr2_ra sequence is 0, 2, 5, 7 on consecutive cycles.
  - first_multiple is 1 only on the first cycle.
  - stall_fetch pattern is 1, 1, 1, 0; returns to IDLE after 4 cycles.
- SM ir=16'h7080 (single bit 7): one cycle with modify_ir=1, modify_pr2_ra=7, first_multiple=1, stall_fetch=0; state stays IDLE.
- LM ir=16'h6200 (mask 0): kill=1 for one cycle; modify_ir=0 and stall_fetch=0.
- Mask 8'hFF with stall_in=1 on the third micro-op for 2 cycles: modify_pr2_ra holds at 2 for 3 cycles, then 3..7 follow; 8 micro-ops total.
- Mask 8'h0F with flush=1 on the second micro-op: the next cycle has all outputs 0 and the state is IDLE. A following ADD in IF/ID passes with modify_ir=0.
- Reset driven low mid-sequence (mask 8'hF0, after micro-op 4): all outputs go to 0 immediately (asynchronously). After release with valid=0, the state is IDLE and remaining is 0.
